// File: rtl/counter_timer_high_if.sv
// Register bus and chain-link signals between the high counter half and its wrapper/low half.
interface counter_timer_high_if;
    logic        reg_cfg_we;
    logic [31:0] reg_cfg_di;
    logic [31:0] reg_cfg_do;
    logic [3:0]  reg_val_we;
    logic [31:0] reg_val_di;
    logic [31:0] reg_val_do;
    logic [3:0]  reg_dat_we;
    logic [31:0] reg_dat_di;
    logic [31:0] reg_dat_do;
    logic        strobe;
    logic        is_offset;
    logic        enable_in;
    logic        stop_in;
    logic        stop_out;
    logic        enable_out;
    logic        irq_out;

    modport master (
        output reg_cfg_we, reg_cfg_di, reg_val_we, reg_val_di, reg_dat_we, reg_dat_di,
        output strobe, is_offset, enable_in, stop_in,
        input  reg_cfg_do, reg_val_do, reg_dat_do, stop_out, enable_out, irq_out
    );

    modport slave (
        input  reg_cfg_we, reg_cfg_di, reg_val_we, reg_val_di, reg_dat_we, reg_dat_di,
        input  strobe, is_offset, enable_in, stop_in,
        output reg_cfg_do, reg_val_do, reg_dat_do, stop_out, enable_out, irq_out
    );
endinterface

// File: rtl/counter_timer_high.sv
// Upper 32-bit half of the chained 64-bit counter/timer; standalone 32-bit timer when chain=0.
module counter_timer_high (
    input  logic                 clkin,
    input  logic                 resetn,
    counter_timer_high_if.slave  bus
);
    logic        r_enable;
    logic        r_oneshot;
    logic        r_updown;
    logic        r_chain;
    logic        r_irq_ena;
    logic [31:0] r_value_reset;
    logic [31:0] r_value_cur;
    logic        r_stop_out;
    logic        r_irq_out;
    logic        r_lastenable;
    logic        r_last_term;

    logic        w_loc_enable;
    logic        w_term;
    logic        w_irq_nxt;
    logic [31:0] w_tgt;
    logic [31:0] w_step;
    logic [31:0] w_reload;
    logic [31:0] w_value_reset_nxt;
    logic [31:0] w_cur_nxt;
    logic        w_stop_nxt;
    logic        w_unused;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  we);
        logic [31:0] res;
        res[7:0]   = we[0] ? new_v[7:0]   : old_v[7:0];
        res[15:8]  = we[1] ? new_v[15:8]  : old_v[15:8];
        res[23:16] = we[2] ? new_v[23:16] : old_v[23:16];
        res[31:24] = we[3] ? new_v[31:24] : old_v[31:24];
        return res;
    endfunction

    assign w_unused     = ^bus.reg_cfg_di[31:5];
    assign w_loc_enable = r_chain ? (r_enable & bus.enable_in) : r_enable;
    assign w_tgt        = r_updown ? (r_value_reset - {31'd0, bus.is_offset}) : '0;
    assign w_step       = r_updown ? (r_value_cur + 32'd1) : (r_value_cur - 32'd1);
    assign w_reload     = r_updown ? '0 : r_value_reset;
    // In chain mode a terminal event needs both halves at their terminal value.
    assign w_term       = r_chain ? (bus.stop_in & r_stop_out) : r_stop_out;
    assign w_irq_nxt    = w_loc_enable & r_irq_ena & w_term & ~r_last_term & ~r_irq_out;
    assign w_value_reset_nxt = byte_merge(r_value_reset, bus.reg_val_di, bus.reg_val_we);

    always_comb begin
        w_cur_nxt  = r_value_cur;
        w_stop_nxt = r_stop_out;
        if (bus.reg_dat_we != 4'd0) begin
            w_cur_nxt = byte_merge(r_value_cur, bus.reg_dat_di, bus.reg_dat_we);
        end else if (w_loc_enable) begin
            if (!r_lastenable) begin
                w_cur_nxt  = w_reload;
                w_stop_nxt = 1'b0;
            end else if (!r_chain) begin
                if (r_value_cur == w_tgt) begin
                    if (r_oneshot) begin
                        w_stop_nxt = 1'b1;
                    end else begin
                        w_cur_nxt  = w_reload;
                        w_stop_nxt = 1'b0;
                    end
                end else begin
                    w_cur_nxt  = w_step;
                    w_stop_nxt = (w_step == w_tgt);
                end
            end else if (bus.stop_in && r_stop_out) begin
                // Reload on the same edge as the low half so the pair restarts together.
                if (r_oneshot) begin
                    w_stop_nxt = 1'b1;
                end else begin
                    w_cur_nxt  = w_reload;
                    w_stop_nxt = 1'b0;
                end
            end else if (bus.strobe) begin
                w_cur_nxt  = w_step;
                w_stop_nxt = (w_step == w_tgt);
            end else begin
                w_stop_nxt = (r_value_cur == w_tgt);
            end
        end
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            r_enable      <= 1'b0;
            r_oneshot     <= 1'b0;
            r_updown      <= 1'b0;
            r_chain       <= 1'b0;
            r_irq_ena     <= 1'b0;
            r_value_reset <= '0;
            r_value_cur   <= '0;
            r_stop_out    <= 1'b0;
            r_irq_out     <= 1'b0;
            r_lastenable  <= 1'b0;
            r_last_term   <= 1'b0;
        end else begin
            if (bus.reg_cfg_we) begin
                r_enable  <= bus.reg_cfg_di[0];
                r_oneshot <= bus.reg_cfg_di[1];
                r_updown  <= bus.reg_cfg_di[2];
                r_chain   <= bus.reg_cfg_di[3];
                r_irq_ena <= bus.reg_cfg_di[4];
            end
            r_value_reset <= w_value_reset_nxt;
            r_value_cur   <= w_cur_nxt;
            r_stop_out    <= w_stop_nxt;
            r_irq_out     <= w_irq_nxt;
            r_lastenable  <= w_loc_enable;
            r_last_term   <= w_term;
        end
    end

    assign bus.reg_cfg_do = {27'd0, r_irq_ena, r_chain, r_updown, r_oneshot, r_enable};
    assign bus.reg_val_do = r_value_reset;
    assign bus.reg_dat_do = r_value_cur;
    assign bus.stop_out   = r_stop_out;
    assign bus.enable_out = r_enable;
    assign bus.irq_out    = r_irq_out;
endmodule

// File: tb/tb_counter_timer_high.sv
// Directed scoreboard bench for counter_timer_high: expectations queued per step, checked after each edge.
module tb_counter_timer_high;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    typedef struct packed {
        logic [31:0] cur;
        logic        stop;
        logic        irq;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];

    counter_timer_high_if bus ();

    counter_timer_high dut (
        .clkin  (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] cur, input logic stop, input logic irq);
        exp_t e;
        e.cur  = cur;
        e.stop = stop;
        e.irq  = irq;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic tick();
        exp_t  e;
        string t;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            t = sb_tag.pop_front();
            chk({t, ".cur"},  bus.reg_dat_do, e.cur);
            chk({t, ".stop"}, {31'd0, bus.stop_out}, {31'd0, e.stop});
            chk({t, ".irq"},  {31'd0, bus.irq_out},  {31'd0, e.irq});
        end
    endtask

    task automatic step(input string tag, input logic [31:0] cur, input logic stop, input logic irq);
        expect_out(tag, cur, stop, irq);
        tick();
    endtask

    task automatic wr_cfg(input logic [31:0] d);
        bus.reg_cfg_we = 1'b1;
        bus.reg_cfg_di = d;
        tick();
        bus.reg_cfg_we = 1'b0;
        bus.reg_cfg_di = '0;
    endtask

    task automatic wr_val(input logic [31:0] d);
        bus.reg_val_we = 4'hF;
        bus.reg_val_di = d;
        tick();
        bus.reg_val_we = 4'h0;
        bus.reg_val_di = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        bus.reg_cfg_we = 1'b0; bus.reg_cfg_di = '0;
        bus.reg_val_we = 4'h0; bus.reg_val_di = '0;
        bus.reg_dat_we = 4'h0; bus.reg_dat_di = '0;
        bus.strobe = 1'b0; bus.is_offset = 1'b0;
        bus.enable_in = 1'b0; bus.stop_in = 1'b0;

        step("reset", 32'd0, 1'b0, 1'b0);
        tick();
        chk("reset.cfg", bus.reg_cfg_do, 32'd0);
        chk("reset.val", bus.reg_val_do, 32'd0);
        chk("reset.enout", {31'd0, bus.enable_out}, 32'd0);
        rst_n = 1'b1;

        // 1: standalone down continuous, value_reset=3
        wr_val(32'd3);
        chk("t1.val", bus.reg_val_do, 32'd3);
        wr_cfg(32'h0000_0001);
        chk("t1.cfg", bus.reg_cfg_do, 32'd1);
        chk("t1.enout", {31'd0, bus.enable_out}, 32'd1);
        step("t1.rise", 32'd3, 1'b0, 1'b0);
        step("t1.c2",   32'd2, 1'b0, 1'b0);
        step("t1.c1",   32'd1, 1'b0, 1'b0);
        step("t1.c0",   32'd0, 1'b1, 1'b0);
        step("t1.rl3",  32'd3, 1'b0, 1'b0);
        step("t1.rl2",  32'd2, 1'b0, 1'b0);
        expect_out("t1.off", 32'd1, 1'b0, 1'b0);
        wr_cfg(32'h0000_0000);
        step("t1.hold", 32'd1, 1'b0, 1'b0);

        // 2: standalone up oneshot with irq, value_reset=5
        wr_val(32'd5);
        wr_cfg(32'h0000_0017);
        step("t2.rise", 32'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) step("t2.cnt", k, 1'b0, 1'b0);
        step("t2.term", 32'd5, 1'b1, 1'b0);
        step("t2.irq",  32'd5, 1'b1, 1'b1);
        step("t2.h1",   32'd5, 1'b1, 1'b0);
        step("t2.h2",   32'd5, 1'b1, 1'b0);
        expect_out("t2.off", 32'd5, 1'b1, 1'b0);
        wr_cfg(32'h0000_0000);

        // 3: chained up, strobe every 4th cycle, then enable_in low freezes count
        bus.enable_in = 1'b1;
        wr_val(32'd100);
        wr_cfg(32'h0000_000D);
        step("t3.rise", 32'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            for (int j = 0; j < 3; j++) step("t3.idle", k - 1, 1'b0, 1'b0);
            bus.strobe = 1'b1;
            step("t3.strobe", k, 1'b0, 1'b0);
            bus.strobe = 1'b0;
        end
        bus.enable_in = 1'b0;
        for (int j = 0; j < 8; j++) begin
            bus.strobe = j[0];
            step("t3.frozen", 32'd3, 1'b0, 1'b0);
        end
        bus.strobe = 1'b0;
        chk("t3.enout", {31'd0, bus.enable_out}, 32'd1);
        bus.enable_in = 1'b1;
        step("t3.rerise", 32'd0, 1'b0, 1'b0);

        // 4: chained up, value_reset=2, target shifts with is_offset
        expect_out("t4.wr", 32'd0, 1'b0, 1'b0);
        wr_val(32'd2);
        bus.is_offset = 1'b1;
        step("t4.off1", 32'd0, 1'b0, 1'b0);
        bus.strobe = 1'b1;
        step("t4.at1", 32'd1, 1'b1, 1'b0);
        bus.strobe = 1'b0;
        step("t4.hold1", 32'd1, 1'b1, 1'b0);
        bus.is_offset = 1'b0;
        step("t4.off0", 32'd1, 1'b0, 1'b0);
        bus.strobe = 1'b1;
        step("t4.at2", 32'd2, 1'b1, 1'b0);
        bus.strobe = 1'b0;
        step("t4.hold2", 32'd2, 1'b1, 1'b0);

        // 5: chained continuous, stop_in pulse with stop_out high -> reload + one irq
        expect_out("t5.cfg", 32'd2, 1'b1, 1'b0);
        wr_cfg(32'h0000_001D);
        bus.stop_in = 1'b1;
        step("t5.reload", 32'd0, 1'b0, 1'b1);
        bus.stop_in = 1'b0;
        step("t5.after", 32'd0, 1'b0, 1'b0);
        step("t5.quiet", 32'd0, 1'b0, 1'b0);

        // 6: data write beats strobe; byte write; async reset mid-count
        bus.reg_dat_we = 4'hF;
        bus.reg_dat_di = 32'hDEAD_BEEF;
        bus.strobe = 1'b1;
        step("t6.wr", 32'hDEAD_BEEF, 1'b0, 1'b0);
        bus.reg_dat_we = 4'h0;
        bus.strobe = 1'b0;
        step("t6.hold", 32'hDEAD_BEEF, 1'b0, 1'b0);
        bus.strobe = 1'b1;
        step("t6.inc", 32'hDEAD_BEF0, 1'b0, 1'b0);
        bus.strobe = 1'b0;
        bus.reg_dat_we = 4'b0010;
        bus.reg_dat_di = 32'h0000_1200;
        step("t6.byte", 32'hDEAD_12F0, 1'b0, 1'b0);
        bus.reg_dat_we = 4'h0;
        bus.reg_dat_di = '0;
        bus.strobe = 1'b1;
        step("t6.inc2", 32'hDEAD_12F1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.arst.cur", bus.reg_dat_do, 32'd0);
        chk("t6.arst.cfg", bus.reg_cfg_do, 32'd0);
        chk("t6.arst.val", bus.reg_val_do, 32'd0);
        chk("t6.arst.enout", {31'd0, bus.enable_out}, 32'd0);
        step("t6.inrst", 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step("t6.post", 32'd0, 1'b0, 1'b0);
        bus.strobe = 1'b0;

        // Wrap boundary: standalone up, value_reset=0, is_offset=1 -> target 32'hFFFFFFFF
        bus.is_offset = 1'b1;
        expect_out("tw.cfg", 32'd0, 1'b0, 1'b0);
        wr_cfg(32'h0000_0005);
        step("tw.rise", 32'd0, 1'b0, 1'b0);
        bus.reg_dat_we = 4'hF;
        bus.reg_dat_di = 32'hFFFF_FFFD;
        step("tw.wr", 32'hFFFF_FFFD, 1'b0, 1'b0);
        bus.reg_dat_we = 4'h0;
        step("tw.fe",  32'hFFFF_FFFE, 1'b0, 1'b0);
        step("tw.ff",  32'hFFFF_FFFF, 1'b1, 1'b0);
        step("tw.rl",  32'd0, 1'b0, 1'b0);
        step("tw.one", 32'd1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
